// File: rtl/shreg_ser.sv
// shreg_ser: WIDTH-bit parallel-load register that shifts its word out serially, MSB- or LSB-first.
// Define SHREG_SER_ROTATE_EN to refill with the bit shifted out (rotate) instead of SI.
module shreg_ser #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CK,
    input  logic             RB,
    input  logic             LOAD,
    input  logic             DIR,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             BUSY,
    output logic             DONE
);

    // state | meaning
    // IDLE  | Q holds; waiting for LOAD
    // SHIFT | one shift per EN cycle; cnt = shifts still to do

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic             dir_r, dir_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             done, done_nxt;
    logic             so;
    logic             fill;

    assign so = dir_r ? q[0] : q[WIDTH-1];

`ifdef SHREG_SER_ROTATE_EN
    assign fill = so;
`else
    assign fill = SI;
`endif

    always_ff @(posedge CK) begin
        if (!RB) begin
            state <= IDLE;
            q     <= '0;
            dir_r <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            dir_r <= dir_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        dir_nxt   = dir_r;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (LOAD) begin
                    q_nxt     = D;
                    dir_nxt   = DIR;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (EN) begin
                    if (dir_r) q_nxt = {fill, q[WIDTH-1:1]};
                    else       q_nxt = {q[WIDTH-2:0], fill};
                    cnt_nxt = cnt - CNT_ONE;
                    // the shift that empties the counter ends the word
                    if (cnt == CNT_ONE) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Q    = q;
    assign SO   = so;
    assign BUSY = (state == SHIFT);
    assign DONE = done;

endmodule
